// File: rtl/serial_pkg.sv
// serial_pkg -- shared definitions for the byte-stuffing serial link.
// Holds the default FLAG/ESCAPE/ESC_XOR values used by both the escape
// transmitter and the unescaper, plus the unescaper state encoding.
package serial_pkg;

  localparam logic [7:0] FLAG_DEF    = 8'h7e;
  localparam logic [7:0] ESCAPE_DEF  = 8'h7d;
  localparam logic [7:0] ESC_XOR_DEF = 8'h20;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2,
    ST_ESC  = 2'd3
  } unescape_state_e;

endpackage

// File: rtl/serial_unescape.sv
// serial_unescape -- removes byte stuffing from a UART byte stream and
// delimits frames on FLAG. Every output is registered and responds one
// mclk after the u_data_strobe that causes it.
// Optional feature: define SERIAL_UNESCAPE_LEN_EN to enable frame-length
// tracking (h_length) and the MAX_LEN overflow abort.
module serial_unescape
  import serial_pkg::*;
#(
  parameter logic [7:0] FLAG    = FLAG_DEF,
  parameter logic [7:0] ESCAPE  = ESCAPE_DEF,
  parameter logic [7:0] ESC_XOR = ESC_XOR_DEF,
  parameter int         MAX_LEN = 1024,
  parameter int         LEN_W   = 11
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [7:0]       u_data,
  input  logic             u_data_strobe,
  output logic [7:0]       h_data,
  output logic             h_data_strobe,
  output logic             h_frame_start,
  output logic             h_frame_end,
  output logic             h_abort,
  output logic [LEN_W-1:0] h_length
);

  unescape_state_e state_q, state_d;
  logic       in_frame_q, in_frame_d;   // at least one byte emitted this frame
  logic [7:0] data_q, data_d;
  logic       strobe_q, strobe_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       abort_q, abort_d;
  logic       emit;
  logic [7:0] emit_byte;

`ifdef SERIAL_UNESCAPE_LEN_EN
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
`endif

  // Next-state and next-output decode for one accepted byte.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    in_frame_d = in_frame_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    abort_d    = 1'b0;
    emit       = 1'b0;
    emit_byte  = u_data;
`ifdef SERIAL_UNESCAPE_LEN_EN
    cnt_d      = cnt_q;
    len_d      = '0;
`endif

    if (u_data_strobe) begin
      unique case (state_q)
        ST_HUNT: begin
          if (u_data == FLAG) state_d = ST_IDLE;
        end
        ST_IDLE, ST_DATA: begin
          if (u_data == FLAG) begin
            // A FLAG seen in DATA closes a non-empty frame; in IDLE it is an
            // empty frame and produces nothing.
            if (state_q == ST_DATA) begin
              end_d = 1'b1;
`ifdef SERIAL_UNESCAPE_LEN_EN
              len_d = cnt_q;
`endif
            end
            state_d = ST_IDLE;
          end else if (u_data == ESCAPE) begin
            state_d = ST_ESC;
          end else begin
            emit = 1'b1;
          end
        end
        ST_ESC: begin
          if (u_data == FLAG) begin
            abort_d = 1'b1;
            state_d = ST_IDLE;
          end else if (u_data == ESCAPE) begin
            abort_d = 1'b1;
            state_d = ST_HUNT;
          end else begin
            emit      = 1'b1;
            emit_byte = u_data ^ ESC_XOR;
          end
        end
        default: state_d = ST_HUNT;
      endcase

`ifdef SERIAL_UNESCAPE_LEN_EN
      // A byte that would push the frame past MAX_LEN kills the frame.
      if (emit && (cnt_q >= MAX_LEN_C)) begin
        emit    = 1'b0;
        abort_d = 1'b1;
        state_d = ST_HUNT;
      end else if (emit) begin
        cnt_d = cnt_q + LEN_W'(1);
      end
`endif

      if (emit) begin
        data_d     = emit_byte;
        strobe_d   = 1'b1;
        start_d    = !in_frame_q;
        in_frame_d = 1'b1;
        state_d    = ST_DATA;
      end

      // Leaving a frame (back to IDLE or HUNT) forgets its progress.
      if (state_d == ST_IDLE || state_d == ST_HUNT) begin
        in_frame_d = 1'b0;
`ifdef SERIAL_UNESCAPE_LEN_EN
        cnt_d      = '0;
`endif
      end
    end
  end

  // State and registered outputs; reset discards any frame in progress.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      in_frame_q <= 1'b0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      start_q    <= start_d;
      end_q      <= end_d;
      abort_q    <= abort_d;
    end
  end

`ifdef SERIAL_UNESCAPE_LEN_EN
  // Byte counter and the length reported alongside h_frame_end.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign h_length = len_q;
`else
  assign h_length = '0;
`endif

  assign h_data        = data_q;
  assign h_data_strobe = strobe_q;
  assign h_frame_start = start_q;
  assign h_frame_end   = end_q;
  assign h_abort       = abort_q;

endmodule

// File: tb/tb_serial_unescape.sv
// tb_serial_unescape -- self-checking bench for serial_unescape.
// A frame-level reference model (sync flag, pending-escape flag and a queue
// holding the current frame's bytes) predicts the outputs of every cycle.
// Directed sequences cover the documented scenarios, then random traffic.
module tb_serial_unescape;

  localparam logic [7:0] FLAG    = 8'h7e;
  localparam logic [7:0] ESCAPE  = 8'h7d;
  localparam logic [7:0] ESC_XOR = 8'h20;
  localparam int         MAXL    = 8;
  localparam int         LEN_W   = 11;
`ifdef SERIAL_UNESCAPE_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic             mclk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       u_data = 8'h00;
  logic             u_data_strobe = 1'b0;
  logic [7:0]       h_data;
  logic             h_data_strobe;
  logic             h_frame_start;
  logic             h_frame_end;
  logic             h_abort;
  logic [LEN_W-1:0] h_length;

  serial_unescape #(
    .FLAG(FLAG), .ESCAPE(ESCAPE), .ESC_XOR(ESC_XOR), .MAX_LEN(MAXL), .LEN_W(LEN_W)
  ) dut (
    .mclk(mclk), .reset(reset),
    .u_data(u_data), .u_data_strobe(u_data_strobe),
    .h_data(h_data), .h_data_strobe(h_data_strobe),
    .h_frame_start(h_frame_start), .h_frame_end(h_frame_end),
    .h_abort(h_abort), .h_length(h_length)
  );

  always #10 mclk = ~mclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state.
  bit         m_sync;
  bit         m_esc;
  logic [7:0] m_frame[$];
  logic [7:0] m_data;
  // Expected outputs for the cycle being predicted.
  bit         e_strobe, e_start, e_end, e_abort;
  int         e_len;

  function automatic void model_reset();
    m_sync = 1'b0;
    m_esc  = 1'b0;
    m_frame.delete();
    m_data = 8'h00;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (LEN_EN && m_frame.size() == MAXL) begin
      e_abort = 1'b1;
      m_sync  = 1'b0;
      m_frame.delete();
    end else begin
      e_strobe = 1'b1;
      e_start  = (m_frame.size() == 0);
      m_data   = b;
      m_frame.push_back(b);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_sync) begin
      if (b == FLAG) begin
        m_sync = 1'b1;
        m_frame.delete();
      end
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (b == FLAG) begin
        e_abort = 1'b1;
        m_frame.delete();
      end else if (b == ESCAPE) begin
        e_abort = 1'b1;
        m_sync  = 1'b0;
        m_frame.delete();
      end else begin
        model_push(b ^ ESC_XOR);
      end
    end else if (b == FLAG) begin
      if (m_frame.size() > 0) begin
        e_end = 1'b1;
        e_len = m_frame.size();
      end
      m_frame.delete();
    end else if (b == ESCAPE) begin
      m_esc = 1'b1;
    end else begin
      model_push(b);
    end
  endfunction

  task automatic check_outputs(input string ctx);
    check({ctx, ".strobe"}, 32'(h_data_strobe), 32'(e_strobe));
    check({ctx, ".data"},   32'(h_data),        32'(m_data));
    check({ctx, ".start"},  32'(h_frame_start), 32'(e_start));
    check({ctx, ".end"},    32'(h_frame_end),   32'(e_end));
    check({ctx, ".abort"},  32'(h_abort),       32'(e_abort));
    if (!LEN_EN) check({ctx, ".len0"}, 32'(h_length), 32'd0);
    else if (e_end) check({ctx, ".len"}, 32'(h_length), 32'(e_len));
  endtask

  // One mclk: present a byte (or nothing), then compare after the edge.
  task automatic step(input bit stb, input logic [7:0] b, input string ctx);
    u_data        = b;
    u_data_strobe = stb;
    e_strobe = 1'b0; e_start = 1'b0; e_end = 1'b0; e_abort = 1'b0; e_len = 0;
    if (stb) model_byte(b);
    @(posedge mclk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic send(input logic [7:0] q[$], input string ctx);
    foreach (q[i]) step(1'b1, q[i], ctx);
    step(1'b0, 8'h00, ctx);
  endtask

  task automatic check_reset_zero(input string ctx);
    check({ctx, ".rst_data"},  32'(h_data), 32'd0);
    check({ctx, ".rst_pulse"}, 32'({h_data_strobe, h_frame_start, h_frame_end, h_abort}), 32'd0);
    check({ctx, ".rst_len"},   32'(h_length), 32'd0);
  endtask

  logic [7:0] seq[$];

  initial begin
    model_reset();
    #25;
    check_reset_zero("por");
    @(negedge mclk);
    reset = 1'b1;
    @(posedge mclk);
    #1;

    seq = '{8'h41, 8'h7e, 8'h01, 8'h02, 8'h7e};
    send(seq, "drop_first");
    seq = '{8'h7e, 8'h7d, 8'h5e, 8'h7d, 8'h5d, 8'h7e};
    send(seq, "escaped");
    seq = '{8'h7e, 8'h7e, 8'h7e};
    send(seq, "empty");
    seq = '{8'h7e, 8'h33, 8'h7d, 8'h7e, 8'h44, 8'h7e};
    send(seq, "esc_flag");
    seq = '{8'h7e, 8'h55, 8'h7d, 8'h7d, 8'h66, 8'h7e, 8'h77, 8'h7e};
    send(seq, "esc_esc");
    seq = '{8'h7e, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h7e};
    send(seq, "maxlen");
    seq = '{8'h7e, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7e};
    send(seq, "exact_max");

    // Reset mid-frame: outputs drop at once, no abort, resync needed.
    seq = '{8'h7e, 8'h11, 8'h22};
    foreach (seq[i]) step(1'b1, seq[i], "pre_rst");
    reset = 1'b0;
    model_reset();
    #2;
    check_reset_zero("mid_rst");
    @(posedge mclk);
    #1;
    check_reset_zero("mid_rst_hold");
    @(negedge mclk);
    reset = 1'b1;
    @(posedge mclk);
    #1;
    seq = '{8'h33, 8'h44, 8'h7e, 8'h55, 8'h7e};
    send(seq, "post_rst");

    // Random traffic biased towards FLAG and ESCAPE, with idle gaps.
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 9);
      if (r < 2)       b = FLAG;
      else if (r == 2) b = ESCAPE;
      else             b = 8'($urandom);
      step($urandom_range(0, 4) != 0, b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
